// File: rtl/thief_pkg.sv
// Shared definitions for the intrusion-detection path: controller states,
// default limits and the j/k command encoding understood by the alarm latch.
package thief_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ALARM = 2'd2
  } state_e;

  localparam int DEF_MAX_FAIL    = 3;
  localparam int DEF_LOCK_CYCLES = 50;

  // {j, k} command pair driven into the alarm JK latch
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that times the lockout window. done_o is high for
// the single cycle in which an enabled count of 1 is about to reach 0, so the
// controller can leave ALARM on the same edge the count hits zero.
module lock_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic [TMR_W-1:0] remain_o,
  output logic             done_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Next count: clear beats load beats decrement; the count saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  // Count register, cleared asynchronously with the rest of the controller
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign remain_o = cnt_q;
  assign done_o   = enable_i && (cnt_q == TMR_W'(1));

endmodule

// File: rtl/thief_alarm_ctrl.sv
// Intrusion-detection controller: counts consecutive failed code entries,
// raises the alarm latch (j) and a timed lockout when the limit is reached,
// and clears the latch (k) when the window expires or a supervisor cancels.
module thief_alarm_ctrl
  import thief_pkg::*;
#(
  parameter int MAX_FAIL    = DEF_MAX_FAIL,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int CNT_W       = 4,
  parameter int TMR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pass_ok,
  input  logic             pass_fail,
  input  logic             admin_clear,
  output logic             alarm_j,
  output logic             alarm_k,
  output logic             lockout,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [TMR_W-1:0] lock_remain
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_FAIL);
  localparam logic [TMR_W-1:0] LOCK_VAL = TMR_W'(LOCK_CYCLES);

  state_e           state_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic             lockout_q;
  logic [1:0]       jk_q;

  logic [CNT_W-1:0] failNext;
  logic             counting;
  logic             hitLimit;
  logic             timerLoad;
  logic             timerEnable;
  logic             timerClear;
  logic             timerDone;

  // Timer control derived from the same decisions the FSM makes this edge
  always_comb begin
    failNext    = fail_cnt_q + CNT_W'(1);
    counting    = (state_q == IDLE) || (state_q == COUNT);
    hitLimit    = counting && !admin_clear && pass_fail && (failNext == MAX_CNT);
    timerLoad   = hitLimit;
    timerEnable = (state_q == ALARM) && !admin_clear;
    timerClear  = ((state_q == ALARM) && admin_clear) ||
                  (!counting && (state_q != ALARM));
  end

  lock_timer #(
    .TMR_W(TMR_W)
  ) u_lock_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timerLoad),
    .load_val_i(LOCK_VAL),
    .enable_i  (timerEnable),
    .clear_i   (timerClear),
    .remain_o  (lock_remain),
    .done_o    (timerDone)
  );

  // Controller FSM with registered count, lockout and one-cycle j/k commands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fail_cnt_q <= '0;
      lockout_q  <= 1'b0;
      jk_q       <= JK_HOLD;
    end else begin
      jk_q <= JK_HOLD;
      case (state_q)
        IDLE, COUNT: begin
          if (admin_clear) begin
            state_q    <= IDLE;
            fail_cnt_q <= '0;
            lockout_q  <= 1'b0;
            jk_q       <= JK_CLR;
          end else if (pass_fail) begin
            if (failNext == MAX_CNT) begin
              state_q    <= ALARM;
              fail_cnt_q <= MAX_CNT;
              lockout_q  <= 1'b1;
              jk_q       <= JK_SET;
            end else begin
              state_q    <= COUNT;
              fail_cnt_q <= failNext;
            end
          end else if (pass_ok) begin
            state_q    <= IDLE;
            fail_cnt_q <= '0;
          end
        end
        ALARM: begin
          if (admin_clear || timerDone) begin
            state_q    <= IDLE;
            fail_cnt_q <= '0;
            lockout_q  <= 1'b0;
            jk_q       <= JK_CLR;
          end else begin
            fail_cnt_q <= MAX_CNT;
            lockout_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          fail_cnt_q <= '0;
          lockout_q  <= 1'b0;
          jk_q       <= JK_HOLD;
        end
      endcase
    end
  end

  assign alarm_j  = jk_q[1];
  assign alarm_k  = jk_q[0];
  assign lockout  = lockout_q;
  assign fail_cnt = fail_cnt_q;

endmodule
